// File: rtl/uart_bus_loader.sv
// uart_bus_loader: serial-port driven bus initiator for board bring-up.
// Receives 'W'/'R' command frames from the UART receiver, performs one
// 32-bit device bus access per frame and replies through the UART
// transmitter (ACK for writes, 4 data bytes LSB first for reads, NAK
// for unknown commands).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rxdReady_i/rxdData_i received byte strobe and data
//   txdBusy_i            transmitter busy
//   txdStart_o/txdData_o transmit start pulse and byte
//   devEnable_o/devWrite_o/devBusy_i   bus request, direction, wait
//   devDataSave_o/devDataLoad_i        write / read data
//   devPhysicalAddr_o/devByteSelect_o  address, byte lanes
//   active_o             high while a frame is being handled
module uart_bus_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o,
    output logic        devEnable_o,
    output logic        devWrite_o,
    input  logic        devBusy_i,
    output logic [31:0] devDataSave_o,
    input  logic [31:0] devDataLoad_i,
    output logic [31:0] devPhysicalAddr_o,
    output logic [3:0]  devByteSelect_o,
    output logic        active_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_TX,
        S_GUARD
    } state_t;

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   reply_q, reply_d;
    logic [1:0]    left_q, left_d;
    logic [7:0]    txd_q, txd_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            idx_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            reply_q <= 32'd0;
            left_q  <= 2'd0;
            txd_q   <= 8'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reply_q <= reply_d;
            left_q  <= left_d;
            txd_q   <= txd_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        reply_d = reply_q;
        left_d  = left_q;
        txd_d   = txd_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                idx_d = 2'd0;
                if (rxdReady_i) begin
                    if (rxdData_i == CMD_W || rxdData_i == CMD_R) begin
                        wr_d    = (rxdData_i == CMD_W);
                        state_d = S_ADDR;
                    end else begin
                        txd_d   = NAK_BYTE;
                        left_d  = 2'd0;
                        state_d = S_TX;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                // Expiry has priority over a byte arriving on the same edge.
                if (tmo_q == TMO_MAX) begin
                    state_d = S_IDLE;
                end else if (rxdReady_i) begin
                    tmo_d = '0;
                    idx_d = 2'(idx_q + 2'd1);
                    // Fields arrive LSB first: shift new bytes in at the top.
                    if (state_q == S_ADDR) begin
                        addr_d = {rxdData_i, addr_q[31:8]};
                    end else begin
                        wdata_d = {rxdData_i, wdata_q[31:8]};
                    end
                    if (idx_q == 2'd3) begin
                        if (state_q == S_ADDR && wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS;
                        end
                    end
                end else begin
                    tmo_d = TW'(tmo_q + 1'b1);
                end
            end
            S_BUS: begin
                if (!devBusy_i) begin
                    state_d = S_TX;
                    if (wr_q) begin
                        txd_d  = ACK_BYTE;
                        left_d = 2'd0;
                    end else begin
                        reply_d = devDataLoad_i;
                        txd_d   = devDataLoad_i[7:0];
                        left_d  = 2'd3;
                    end
                end
            end
            S_TX: begin
                if (!txdBusy_i) begin
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                if (left_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    left_d  = 2'(left_q - 2'd1);
                    reply_d = {8'd0, reply_q[31:8]};
                    txd_d   = reply_q[15:8];
                    state_d = S_TX;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from the state so reset clears them immediately.
    always_comb begin
        devEnable_o       = (state_q == S_BUS);
        devWrite_o        = (state_q == S_BUS) && wr_q;
        devPhysicalAddr_o = (state_q == S_BUS) ? addr_q : 32'd0;
        devDataSave_o     = ((state_q == S_BUS) && wr_q) ? wdata_q : 32'd0;
        devByteSelect_o   = (state_q == S_BUS) ? 4'hf : 4'h0;
        active_o          = (state_q != S_IDLE);
        txdStart_o        = (state_q == S_TX) && !txdBusy_i;
        txdData_o         = txd_q;
    end

endmodule

// File: tb/tb_uart_bus_loader.sv
// tb_uart_bus_loader: randomized scoreboard bench for uart_bus_loader.
// Stimulus pushes expected bus accesses and reply bytes; a monitor checks.
module tb_uart_bus_loader;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxdReady_i = 1'b0;
    logic [7:0]  rxdData_i = 8'd0;
    logic        txdBusy_i = 1'b0;
    logic        txdStart_o;
    logic [7:0]  txdData_o;
    logic        devEnable_o;
    logic        devWrite_o;
    logic        devBusy_i = 1'b0;
    logic [31:0] devDataSave_o;
    logic [31:0] devDataLoad_i = 32'd0;
    logic [31:0] devPhysicalAddr_o;
    logic [3:0]  devByteSelect_o;
    logic        active_o;

    uart_bus_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .rxdReady_i        (rxdReady_i),
        .rxdData_i         (rxdData_i),
        .txdBusy_i         (txdBusy_i),
        .txdStart_o        (txdStart_o),
        .txdData_o         (txdData_o),
        .devEnable_o       (devEnable_o),
        .devWrite_o        (devWrite_o),
        .devBusy_i         (devBusy_i),
        .devDataSave_o     (devDataSave_o),
        .devDataLoad_i     (devDataLoad_i),
        .devPhysicalAddr_o (devPhysicalAddr_o),
        .devByteSelect_o   (devByteSelect_o),
        .active_o          (active_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] frm[$];

    int tests = 0;
    int fails = 0;
    int wait_cfg = 0;
    int tx_starts = 0;
    bit hold = 1'b0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Reference model: derive the expected bus access and reply bytes
    // straight from the frame contents.
    task automatic model(input logic [31:0] rdata);
        bus_t b;
        if (frm[0] == 8'h57 && frm.size() == 9) begin
            b.wr    = 1'b1;
            b.addr  = {frm[4], frm[3], frm[2], frm[1]};
            b.data  = {frm[8], frm[7], frm[6], frm[5]};
            b.waits = wait_cfg;
            bus_q.push_back(b);
            tx_q.push_back(8'h06);
        end else if (frm[0] == 8'h52 && frm.size() == 5) begin
            b.wr    = 1'b0;
            b.addr  = {frm[4], frm[3], frm[2], frm[1]};
            b.data  = 32'd0;
            b.waits = wait_cfg;
            bus_q.push_back(b);
            for (int i = 0; i < 4; i++) tx_q.push_back(rdata[8*i +: 8]);
        end else if (frm[0] != 8'h57 && frm[0] != 8'h52) begin
            tx_q.push_back(8'h15);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1 rxdReady_i = 1'b1;
        rxdData_i = b;
        @(posedge clk);
        #1 rxdReady_i = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_idle(input string n);
        int k = 0;
        while (active_o && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk(n, 32'(active_o), 32'd0);
    endtask

    task automatic check_empty(input string n);
        chk({n, "_bus_left"}, 32'(bus_q.size()), 32'd0);
        chk({n, "_tx_left"}, 32'(tx_q.size()), 32'd0);
    endtask

    task automatic run_frm(input string n, input logic [31:0] rdata);
        devDataLoad_i = rdata;
        model(rdata);
        foreach (frm[i]) send_byte(frm[i], $urandom_range(0, 3));
        wait_idle({n, "_idle"});
        check_empty(n);
    endtask

    task automatic rand_r();
        frm = {8'h52, 8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom)};
    endtask

    // Responder: busy for wait_cfg cycles of each access, or forever on hold.
    initial begin
        int wl = 0;
        bit acc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!devEnable_o) acc = 1'b0;
            else if (!acc) begin
                acc = 1'b1;
                wl = wait_cfg;
            end else if (wl > 0) wl--;
            devBusy_i = hold || (acc && wl > 0);
        end
    end

    // Transmitter: random busy time after each start.
    initial begin
        int bc = 0;
        forever begin
            @(posedge clk);
            if (txdStart_o) bc = $urandom_range(0, 4);
            else if (bc > 0) bc--;
            #1 txdBusy_i = (bc != 0);
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        int cyc = 0;
        int last = -10;
        int en = 0;
        bus_t b;
        forever begin
            @(negedge clk);
            cyc++;
            if (devEnable_o) begin
                en++;
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'(devEnable_o), 32'd0);
                end else begin
                    b = bus_q[0];
                    chk("bus_write", 32'(devWrite_o), 32'(b.wr));
                    chk("bus_addr", devPhysicalAddr_o, b.addr);
                    if (b.wr) chk("bus_data", devDataSave_o, b.data);
                    chk("bus_bsel", 32'(devByteSelect_o), 32'hf);
                    if (!devBusy_i) begin
                        chk("bus_cycles", 32'(en), 32'(b.waits + 1));
                        void'(bus_q.pop_front());
                    end
                end
            end else begin
                en = 0;
            end
            if (txdStart_o) begin
                chk("tx_while_busy", 32'(txdBusy_i), 32'd0);
                chk("tx_gap", 32'(cyc - last >= 2), 32'd1);
                last = cyc;
                tx_starts++;
                if (tx_q.size() == 0)
                    chk("tx_unexpected", 32'(txdStart_o), 32'd0);
                else
                    chk("tx_byte", 32'(txdData_o), 32'(tx_q.pop_front()));
            end
        end
    end

    initial begin
        int s0;
        int k;
        int kind;
        logic [7:0] bad;
        #2;
        chk("rst_start", 32'(txdStart_o), 32'd0);
        chk("rst_txdata", 32'(txdData_o), 32'd0);
        chk("rst_enable", 32'(devEnable_o), 32'd0);
        chk("rst_write", 32'(devWrite_o), 32'd0);
        chk("rst_wdata", devDataSave_o, 32'd0);
        chk("rst_addr", devPhysicalAddr_o, 32'd0);
        chk("rst_bsel", 32'(devByteSelect_o), 32'd0);
        chk("rst_active", 32'(active_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write, zero wait states, with latency checks.
        wait_cfg = 0;
        frm = {8'h57, 8'h00, 8'h00, 8'h00, 8'h80,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model(32'd0);
        foreach (frm[i]) send_byte(frm[i], 0);
        chk("wr_latency", 32'(devEnable_o), 32'd1);
        @(posedge clk);
        #1 chk("wr_one_cycle", 32'(devEnable_o), 32'd0);
        wait_idle("wr_idle");
        check_empty("wr");

        // Read with three wait states.
        wait_cfg = 3;
        frm = {8'h52, 8'h10, 8'h00, 8'h00, 8'hBF};
        run_frm("rd", 32'h12345678);

        // Unknown command.
        frm = {8'h41};
        run_frm("nak", 32'd0);

        // Timeout on a partial frame, then a normal read.
        frm = {8'h57, 8'h00, 8'h00};
        model(32'd0);
        foreach (frm[i]) send_byte(frm[i], 0);
        repeat (TMO - 5) @(posedge clk);
        #1 chk("tmo_not_early", 32'(active_o), 32'd1);
        repeat (7) @(posedge clk);
        #1 chk("tmo_expired", 32'(active_o), 32'd0);
        check_empty("tmo");
        wait_cfg = 1;
        rand_r();
        run_frm("tmo_rd", $urandom);

        // Extra byte during a read reply must be dropped.
        wait_cfg = 1;
        rand_r();
        devDataLoad_i = $urandom;
        model(devDataLoad_i);
        foreach (frm[i]) send_byte(frm[i], 0);
        s0 = tx_starts;
        k = 0;
        while (tx_starts == s0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drop_reply_started", 32'(tx_starts > s0), 32'd1);
        send_byte(8'h41, 0);
        wait_idle("drop_idle");
        check_empty("drop");

        // Async reset while stuck in BUS.
        hold = 1'b1;
        rand_r();
        frm[1] = 8'hA5;
        model(32'd0);
        foreach (frm[i]) send_byte(frm[i], 0);
        repeat (3) @(posedge clk);
        #3 chk("hold_enable", 32'(devEnable_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_enable", 32'(devEnable_o), 32'd0);
        chk("arst_addr", devPhysicalAddr_o, 32'd0);
        chk("arst_bsel", 32'(devByteSelect_o), 32'd0);
        chk("arst_active", 32'(active_o), 32'd0);
        chk("arst_start", 32'(txdStart_o), 32'd0);
        chk("arst_txdata", 32'(txdData_o), 32'd0);
        bus_q.delete();
        tx_q.delete();
        hold = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cfg = 0;
        frm = {8'h57, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h11, 8'h22, 8'h33, 8'h44};
        run_frm("post_rst", 32'd0);

        // Randomized frames.
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            wait_cfg = $urandom_range(0, 3);
            if (kind < 4) begin
                frm = {8'h57};
                for (int i = 0; i < 8; i++) frm.push_back(8'($urandom));
            end else if (kind < 8) begin
                rand_r();
            end else begin
                do bad = 8'($urandom);
                while (bad == 8'h57 || bad == 8'h52);
                frm = {bad};
            end
            run_frm("rand", $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_bus_loader.md
Name: uart_bus_loader

Overview:
- Bus initiator driven by the serial port; it is the host-side counterpart to the devctrl responder.
- Parses command frames from the UART receiver and issues single-word reads and writes on the device bus (same signals the cpu drives).
- Sends replies through the UART transmitter.
- Used for board bring-up: loading SRAM/VGA memory and peeking device registers without the CPU. The top level muxes bus ownership using active_o.

Parameters:
TIMEOUT_CYCLES, 2500000, clk cycles allowed between bytes of one frame before the partial frame is discarded (100 ms at 25 MHz)
ACK_BYTE, 8'h06, reply byte after a completed write
NAK_BYTE, 8'h15, reply byte for an unknown command byte

Ports:
clk  input  1  system clock (25 MHz domain)
rst  input  1  asynchronous active-high reset
rxdReady_i  input  1  one-cycle pulse; rxdData_i valid in the same cycle
rxdData_i  input  8  received byte
txdBusy_i  input  1  transmitter busy
txdStart_o  output  1  one-cycle pulse starting transmission of txdData_o
txdData_o  output  8  byte to transmit; held stable until the next start pulse
devEnable_o  output  1  bus request
devWrite_o  output  1  1 = write, 0 = read
devBusy_i  input  1  responder not ready
devDataSave_o  output  32  write data
devDataLoad_i  input  32  read data
devPhysicalAddr_o  output  32  access address
devByteSelect_o  output  4  byte lanes; always 4'hf while enabled, else 4'h0
active_o  output  1  high from first command byte accepted until return to IDLE

Behaviour:
- Reset (asynchronous, rst=1) forces state IDLE. All outputs are 0: txdStart_o, txdData_o, devEnable_o, devWrite_o, devDataSave_o, devPhysicalAddr_o, devByteSelect_o, active_o. Byte counter and timeout counter are cleared.
- Frame formats, multi-byte fields LSB first:
  - 'W' (8'h57), then addr[4], then data[4]. Reply: ACK_BYTE.
  - 'R' (8'h52), then addr[4]. Reply: 4 data bytes, LSB first.
  - Any other first byte: reply NAK_BYTE, return to IDLE. No bus access occurs.
- States:
  - IDLE: on rxdReady_i, latch the command, set active_o, go to ADDR (W/R) or TX (NAK).
  - ADDR: collect 4 bytes into the addr register at byte index 0..3. After the 4th, go to DATA for W or BUS for R.
  - DATA: collect 4 bytes into the write-data register, then go to BUS.
  - BUS: assert devEnable_o with devWrite_o, address, data and byte select stable. The access completes on the first rising edge where devEnable_o=1 and devBusy_i=0. Read data is captured on that edge into the reply register. devEnable_o drops the following cycle (exactly one completing cycle). Go to TX.
  - TX: drive txdData_o with the next reply byte. Pulse txdStart_o for 1 cycle only when txdBusy_i=0.
  - TXGUARD: 1 cycle after each pulse, ignoring txdBusy_i. Then return to TX for the next byte, or to IDLE after the last byte (clears active_o).
- Latency: a write frame issues its bus request on the cycle after the 9th byte's rxdReady_i. Zero wait states give devEnable_o high for exactly 1 cycle.
- Timeout: the counter resets on every accepted byte and counts in ADDR/DATA only. On reaching TIMEOUT_CYCLES-1, discard the frame and go to IDLE (no reply, no bus access). The counter saturates and never wraps.
- rxdReady_i pulses arriving in BUS, TX or TXGUARD are dropped silently.
- An rxdReady_i pulse on the same edge as the timeout expiry: the timeout wins and the byte is dropped.
- Address is passed unmodified. No alignment check is made; addr[1:0] is forwarded as received.
- devBusy_i held high indefinitely: the block waits in BUS forever. Only rst recovers it.
- Reset mid-BUS or mid-TX: outputs drop asynchronously and no reply is sent.

Test Plan:
- Write, zero wait: bytes 57 00 00 00 80 EF BE AD DE -> one devEnable_o cycle with addr 0x80000000, data 0xDEADBEEF, devWrite_o=1, byteSelect 4'hf; then txdData_o=0x06 and a single txdStart_o pulse; active_o low afterwards.
- Read with wait states: bytes 52 10 00 00 BF, devBusy_i high for 3 cycles, then low with devDataLoad_i=0x12345678 -> devEnable_o high for 4 cycles; transmits 78,56,34,12 in order, each start only while txdBusy_i=0 and separated by at least the guard cycle.
- Bad command: byte 0x41 -> txdData_o=0x15 transmitted, devEnable_o never asserted, back to IDLE.
- Timeout: bytes 57 00 00, then silence for TIMEOUT_CYCLES (override to 100 in the bench) -> return to IDLE with no reply. A following 52 frame then executes normally.
- Drop during reply: send an extra byte while transmitting the R reply -> it is ignored, and the reply bytes are unchanged.
- Async reset asserted mid-BUS with devBusy_i=1 -> all outputs 0 immediately with no clock edge; after release the block accepts a new frame.
